// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
// Holds control-word bit positions and layout, ALU/branch/muldiv encodings,
// the muldiv FSM state type and the divide special-case constants.
package ex_pkg;

    localparam int unsigned XLEN = 32;

    // Control-word bit positions
    localparam int unsigned CTRL_ALU_OP_LSB   = 0;
    localparam int unsigned CTRL_FUNCT3_LSB   = 4;
    localparam int unsigned CTRL_USE_IMM_BIT  = 7;
    localparam int unsigned CTRL_BR_BIT       = 8;
    localparam int unsigned CTRL_JAL_BIT      = 9;
    localparam int unsigned CTRL_JALR_BIT     = 10;
    localparam int unsigned CTRL_LUI_BIT      = 11;
    localparam int unsigned CTRL_AUIPC_BIT    = 12;
    localparam int unsigned CTRL_MEM_READ_BIT = 13;
    localparam int unsigned CTRL_MEM_WRITE_BIT= 14;
    localparam int unsigned CTRL_REG_WRITE_BIT= 15;
    localparam int unsigned CTRL_MULDIV_BIT   = 16;
    localparam int unsigned CTRL_VALID_BIT    = 31;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Control word as delivered by the ID/EX register; all-zero is a bubble
    typedef struct packed {
        logic        valid;
        logic [13:0] rsvd;
        logic        muldiv;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        auipc;
        logic        lui;
        logic        jalr;
        logic        jal;
        logic        br;
        logic        use_imm;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
    } ctrl_t;

    // Branch conditions (funct3)
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Muldiv operations (funct3)
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [5:0]  MD_ITERS         = 6'd32;
    localparam logic [31:0] DIV_ZERO_QUO     = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUO      = 32'h8000_0000;
    localparam logic [31:0] DIV_OVF_REM      = 32'h0000_0000;

endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX-to-EX/MEM bus of the execute stage.
// master: upstream pipeline side (drives operands/control, sees results).
// slave:  ex_stage side.
interface ex_if;
    logic [31:0] d1_in;
    logic [31:0] d2_in;
    logic [4:0]  rd_in;
    logic [31:0] imm_in;
    logic [31:0] ctrl_in;
    logic [31:0] pc_in;

    logic        branch;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] result_out;
    logic [31:0] store_data_out;
    logic [4:0]  rd_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        reg_write_out;
    logic [2:0]  mem_size_out;

    modport master (
        output d1_in, d2_in, rd_in, imm_in, ctrl_in, pc_in,
        input  branch, branch_target, stall, result_out, store_data_out,
               rd_out, mem_read_out, mem_write_out, reg_write_out, mem_size_out
    );

    modport slave (
        input  d1_in, d2_in, rd_in, imm_in, ctrl_in, pc_in,
        output branch, branch_target, stall, result_out, store_data_out,
               rd_out, mem_read_out, mem_write_out, reg_write_out, mem_size_out
    );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M unit, fixed 34-cycle occupancy.
// Ports: clock, reset (sync, active-high); start/op/a/b in;
//        busy_c (BUSY state), done_c (DONE state), result_c (valid in DONE).
// Multiply: radix-2 shift-add on magnitudes. Divide: restoring on magnitudes.
// Signs are applied at the end; divide special cases override the datapath.
module muldiv_iter
    import ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy_c,
    output logic        done_c,
    output logic [31:0] result_c
);

    md_state_e   state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;          // mul: {hi, multiplier}; div: {rem, quotient}
    logic [31:0] opnd_q, opnd_d;        // mul: multiplicand; div: divisor
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;          // product / quotient sign
    logic        rneg_q, rneg_d;        // remainder sign (follows dividend)
    logic [31:0] dividend_q, dividend_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q, ovf_d;

    // Operand decode at load time
    logic        ld_is_div, ld_a_signed, ld_b_signed, ld_a_neg, ld_b_neg;
    logic [31:0] ld_mag_a, ld_mag_b;

    always_comb begin
        ld_is_div   = op[2];
        ld_a_signed = ld_is_div ? ~op[0] : (op != MD_MULHU);
        ld_b_signed = ld_is_div ? ~op[0] : ((op == MD_MUL) || (op == MD_MULH));
        ld_a_neg    = ld_a_signed & a[31];
        ld_b_neg    = ld_b_signed & b[31];
        ld_mag_a    = ld_a_neg ? (32'd0 - a) : a;
        ld_mag_b    = ld_b_neg ? (32'd0 - b) : b;
    end

    // One iteration of each algorithm
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] div_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_step  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift[31:0] - opnd_q;
        div_step  = {(div_ge ? div_sub : div_shift[31:0]), acc_q[30:0], div_ge};
    end

    // FSM next-state and datapath
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dividend_d = dividend_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d    = MD_BUSY;
                    count_d    = MD_ITERS;
                    acc_d      = {32'd0, (ld_is_div ? ld_mag_a : ld_mag_b)};
                    opnd_d     = ld_is_div ? ld_mag_b : ld_mag_a;
                    op_d       = op;
                    neg_d      = ld_a_neg ^ ld_b_neg;
                    rneg_d     = ld_a_neg;
                    dividend_d = a;
                    div_zero_d = (b == 32'd0);
                    ovf_d      = ld_is_div & ld_a_signed & (a == DIV_OVF_DIVIDEND)
                                 & (b == DIV_OVF_DIVISOR);
                end
            end
            MD_BUSY: begin
                count_d = count_q - 6'd1;
                acc_d   = op_q[2] ? div_step : mul_step;
                if (count_q == 6'd1) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            count_q    <= 6'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            op_q       <= 3'd0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            dividend_q <= 32'd0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            dividend_q <= dividend_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sign fix-up and special-case override
    logic [63:0] prod_c;
    logic [31:0] quo_c, rem_c;

    always_comb begin
        prod_c = neg_q ? (64'd0 - acc_q) : acc_q;
        quo_c  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_c  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        if (div_zero_q) begin
            quo_c = DIV_ZERO_QUO;
            rem_c = dividend_q;
        end else if (ovf_q) begin
            quo_c = DIV_OVF_QUO;
            rem_c = DIV_OVF_REM;
        end
        result_c = 32'd0;
        if (state_q == MD_DONE) begin
            if (!op_q[2]) begin
                result_c = (op_q == MD_MUL) ? prod_c[31:0] : prod_c[63:32];
            end else begin
                result_c = op_q[1] ? rem_c : quo_c;
            end
        end
    end

    assign busy_c = (state_q == MD_BUSY);
    assign done_c = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage plus EX/MEM pipeline register.
// Ports: clock, reset (sync, active-high), bus (ex_if.slave).
//   in : d1/d2 operands, rd, imm, control word, pc
//   out: branch/branch_target/stall (combinational), registered results.
// Contains ALU, branch unit, stall logic, output register; muldiv is delegated.
module ex_stage
    import ex_pkg::*;
#(
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic clock,
    input  logic reset,
    ex_if.slave  bus
);

    ctrl_t       ctrl;
    logic        unused_rsvd;
    logic [31:0] op_b_c;
    logic [4:0]  shamt_c;
    logic [31:0] alu_c;
    logic        cond_c;
    logic        stall_c;
    logic        branch_c;
    logic [31:0] target_c;
    logic [31:0] result_c;
    logic        md_done_c;
    logic [31:0] md_result_c;

    assign ctrl        = ctrl_t'(bus.ctrl_in);
    assign unused_rsvd = ^ctrl.rsvd;
    assign op_b_c      = ctrl.use_imm ? bus.imm_in : bus.d2_in;
    assign shamt_c     = op_b_c[4:0];

    // ALU
    always_comb begin
        alu_c = 32'd0;
        case (ctrl.alu_op)
            ALU_ADD:  alu_c = bus.d1_in + op_b_c;
            ALU_SUB:  alu_c = bus.d1_in - op_b_c;
            ALU_SLL:  alu_c = bus.d1_in << shamt_c;
            ALU_SLT:  alu_c = {31'd0, ($signed(bus.d1_in) < $signed(op_b_c))};
            ALU_SLTU: alu_c = {31'd0, (bus.d1_in < op_b_c)};
            ALU_XOR:  alu_c = bus.d1_in ^ op_b_c;
            ALU_SRL:  alu_c = bus.d1_in >> shamt_c;
            ALU_SRA:  alu_c = 32'($signed(bus.d1_in) >>> shamt_c);
            ALU_OR:   alu_c = bus.d1_in | op_b_c;
            ALU_AND:  alu_c = bus.d1_in & op_b_c;
            default:  alu_c = 32'd0;
        endcase
    end

    // Branch condition always compares rs1 against rs2
    always_comb begin
        cond_c = 1'b0;
        case (ctrl.funct3)
            F3_BEQ:  cond_c = (bus.d1_in == bus.d2_in);
            F3_BNE:  cond_c = (bus.d1_in != bus.d2_in);
            F3_BLT:  cond_c = ($signed(bus.d1_in) < $signed(bus.d2_in));
            F3_BGE:  cond_c = ($signed(bus.d1_in) >= $signed(bus.d2_in));
            F3_BLTU: cond_c = (bus.d1_in < bus.d2_in);
            F3_BGEU: cond_c = (bus.d1_in >= bus.d2_in);
            default: cond_c = 1'b0;
        endcase
    end

    assign branch_c = ctrl.valid & ~ctrl.muldiv
                      & (ctrl.jal | ctrl.jalr | (ctrl.br & cond_c));
    assign target_c = ctrl.jalr ? ((bus.d1_in + bus.imm_in) & ~32'd1)
                                : (bus.pc_in + bus.imm_in);
    assign stall_c  = ctrl.valid & ctrl.muldiv & ~md_done_c;

    // Muldiv unit, or a zero-result single-cycle stand-in when disabled
    if (ENABLE_MULDIV) begin : g_md
        logic md_start_c;
        logic md_busy_unused;
        assign md_start_c = ctrl.valid & ctrl.muldiv;
        muldiv_iter u_muldiv (
            .clock    (clock),
            .reset    (reset),
            .start    (md_start_c),
            .op       (ctrl.funct3),
            .a        (bus.d1_in),
            .b        (bus.d2_in),
            .busy_c   (md_busy_unused),
            .done_c   (md_done_c),
            .result_c (md_result_c)
        );
    end else begin : g_no_md
        assign md_done_c   = 1'b1;
        assign md_result_c = 32'd0;
    end

    // Result select
    always_comb begin
        if (ctrl.jal || ctrl.jalr) begin
            result_c = bus.pc_in + 32'd4;
        end else if (ctrl.lui) begin
            result_c = bus.imm_in;
        end else if (ctrl.auipc) begin
            result_c = bus.pc_in + bus.imm_in;
        end else if (ctrl.muldiv) begin
            result_c = md_result_c;
        end else begin
            result_c = alu_c;
        end
    end

    // EX/MEM register; a stalled cycle inserts a bubble
    logic [31:0] result_q, result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        reg_write_q, reg_write_d;
    logic [2:0]  mem_size_q, mem_size_d;

    always_comb begin
        result_d     = 32'd0;
        store_data_d = 32'd0;
        rd_d         = 5'd0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        mem_size_d   = 3'd0;
        if (!stall_c) begin
            result_d     = result_c;
            store_data_d = bus.d2_in;
            rd_d         = bus.rd_in;
            mem_read_d   = ctrl.valid & ctrl.mem_read;
            mem_write_d  = ctrl.valid & ctrl.mem_write;
            reg_write_d  = ctrl.valid & ctrl.reg_write;
            mem_size_d   = ctrl.funct3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result_q     <= 32'd0;
            store_data_q <= 32'd0;
            rd_q         <= 5'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_size_q   <= 3'd0;
        end else begin
            result_q     <= result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_size_q   <= mem_size_d;
        end
    end

    assign bus.branch         = branch_c;
    assign bus.branch_target  = target_c;
    assign bus.stall          = stall_c;
    assign bus.result_out     = result_q;
    assign bus.store_data_out = store_data_q;
    assign bus.rd_out         = rd_q;
    assign bus.mem_read_out   = mem_read_q;
    assign bus.mem_write_out  = mem_write_q;
    assign bus.reg_write_out  = reg_write_q;
    assign bus.mem_size_out   = mem_size_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven bench for ex_stage with hand-computed
// expectations, plus muldiv timing, divide special-case and reset sequences.
module tb_ex_stage;
    import ex_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ex_if bus ();

    ex_stage #(.ENABLE_MULDIV(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] V     = 32'(1) << CTRL_VALID_BIT;
    localparam logic [31:0] UI    = 32'(1) << CTRL_USE_IMM_BIT;
    localparam logic [31:0] BR    = 32'(1) << CTRL_BR_BIT;
    localparam logic [31:0] JAL   = 32'(1) << CTRL_JAL_BIT;
    localparam logic [31:0] JALR  = 32'(1) << CTRL_JALR_BIT;
    localparam logic [31:0] LUI   = 32'(1) << CTRL_LUI_BIT;
    localparam logic [31:0] AUIPC = 32'(1) << CTRL_AUIPC_BIT;
    localparam logic [31:0] MR    = 32'(1) << CTRL_MEM_READ_BIT;
    localparam logic [31:0] MW    = 32'(1) << CTRL_MEM_WRITE_BIT;
    localparam logic [31:0] RW    = 32'(1) << CTRL_REG_WRITE_BIT;
    localparam logic [31:0] MD    = 32'(1) << CTRL_MULDIV_BIT;

    typedef struct {
        string       name;
        logic [31:0] ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        exp_branch;
        logic [31:0] exp_target;
        logic [31:0] exp_result;
        logic [2:0]  exp_flags;   // {mem_read, mem_write, reg_write}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input logic [3:0] alu, input logic [2:0] f3,
                                       input logic [31:0] fl);
        return fl | (32'(f3) << CTRL_FUNCT3_LSB) | (32'(alu) << CTRL_ALU_OP_LSB);
    endfunction

    function automatic vec_t v(input string n, input logic [31:0] c, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm,
                               input logic [31:0] pc, input logic [4:0] rd, input logic br,
                               input logic [31:0] tgt, input logic [31:0] res,
                               input logic [2:0] fl);
        vec_t r;
        r.name = n; r.ctrl = c; r.d1 = d1; r.d2 = d2; r.imm = imm; r.pc = pc; r.rd = rd;
        r.exp_branch = br; r.exp_target = tgt; r.exp_result = res; r.exp_flags = fl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] c, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        bus.ctrl_in = c; bus.d1_in = d1; bus.d2_in = d2;
        bus.imm_in = imm; bus.pc_in = pc; bus.rd_in = rd;
    endtask

    // Drives a muldiv op at a non-edge time and follows it to completion.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int stall_cnt;
        int bubble_bad;
        logic done;
        stall_cnt = 0; bubble_bad = 0; done = 1'b0;
        drive(mk(4'(ALU_ADD), f3, V | MD | RW), a, b, 32'd0, 32'd0, 5'd5);
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (bus.stall) begin
                stall_cnt++;
                @(posedge clock); #1;
                if (bus.result_out !== 32'd0 || bus.reg_write_out !== 1'b0 ||
                    bus.rd_out !== 5'd0)
                    bubble_bad++;
                @(negedge clock);
            end else begin
                if (bus.branch !== 1'b0) bubble_bad++;
                @(posedge clock); #1;
                done = 1'b1;
            end
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        chk({name, "_bubbles"}, 64'(bubble_bad), 64'd0);
        chk({name, "_result"}, 64'(bus.result_out), 64'(exp));
        chk({name, "_reg_write"}, 64'(bus.reg_write_out), 64'd1);
        chk({name, "_rd"}, 64'(bus.rd_out), 64'd5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs.push_back(v("add",   mk(4'(ALU_ADD), 3'd0, V|RW), 32'd5, 32'd7, 32'd0, 32'd0, 5'd1, 1'b0, 32'd0, 32'd12, 3'b001));
        vecs.push_back(v("sub",   mk(4'(ALU_SUB), 3'd0, V|RW), 32'd5, 32'd7, 32'd0, 32'd0, 5'd2, 1'b0, 32'd0, 32'hFFFF_FFFE, 3'b001));
        vecs.push_back(v("sra",   mk(4'(ALU_SRA), 3'd5, V|RW|UI), 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd3, 1'b0, 32'd4, 32'hF800_0000, 3'b001));
        vecs.push_back(v("sltu",  mk(4'(ALU_SLTU), 3'd3, V|RW), 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd4, 1'b0, 32'd0, 32'd1, 3'b001));
        vecs.push_back(v("slt",   mk(4'(ALU_SLT), 3'd2, V|RW), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd4, 1'b0, 32'd0, 32'd1, 3'b001));
        vecs.push_back(v("beq",   mk(4'(ALU_ADD), 3'd0, V|BR), 32'd3, 32'd3, 32'h20, 32'h100, 5'd0, 1'b1, 32'h120, 32'd6, 3'b000));
        vecs.push_back(v("bne",   mk(4'(ALU_ADD), 3'd1, V|BR), 32'd3, 32'd3, 32'h20, 32'h100, 5'd0, 1'b0, 32'h120, 32'd6, 3'b000));
        vecs.push_back(v("jalr",  mk(4'(ALU_ADD), 3'd0, V|JALR|RW), 32'h203, 32'd0, 32'd0, 32'h40, 5'd1, 1'b1, 32'h202, 32'h44, 3'b001));
        vecs.push_back(v("jal",   mk(4'(ALU_ADD), 3'd0, V|JAL|RW), 32'd0, 32'd0, 32'h10, 32'h200, 5'd1, 1'b1, 32'h210, 32'h204, 3'b001));
        vecs.push_back(v("lui",   mk(4'(ALU_ADD), 3'd0, V|LUI|RW|UI), 32'd9, 32'd0, 32'h1234_5000, 32'd0, 5'd6, 1'b0, 32'h1234_5000, 32'h1234_5000, 3'b001));
        vecs.push_back(v("auipc", mk(4'(ALU_ADD), 3'd0, V|AUIPC|RW|UI), 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd7, 1'b0, 32'h3000, 32'h3000, 3'b001));
        vecs.push_back(v("blt",   mk(4'(ALU_ADD), 3'd4, V|BR), 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 5'd0, 1'b1, 32'd8, 32'd0, 3'b000));
        vecs.push_back(v("bge",   mk(4'(ALU_ADD), 3'd5, V|BR), 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 5'd0, 1'b0, 32'd8, 32'd0, 3'b000));
        vecs.push_back(v("bltu",  mk(4'(ALU_ADD), 3'd6, V|BR), 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 5'd0, 1'b0, 32'd8, 32'd0, 3'b000));
        vecs.push_back(v("bgeu",  mk(4'(ALU_ADD), 3'd7, V|BR), 32'hFFFF_FFFF, 32'd1, 32'd8, 32'd0, 5'd0, 1'b1, 32'd8, 32'd0, 3'b000));
        vecs.push_back(v("sll",   mk(4'(ALU_SLL), 3'd1, V|RW), 32'd1, 32'd31, 32'd0, 32'd0, 5'd8, 1'b0, 32'd0, 32'h8000_0000, 3'b001));
        vecs.push_back(v("srl",   mk(4'(ALU_SRL), 3'd5, V|RW|UI), 32'h8000_0000, 32'd0, 32'd31, 32'd0, 5'd9, 1'b0, 32'h1F, 32'd1, 3'b001));
        vecs.push_back(v("xor",   mk(4'(ALU_XOR), 3'd4, V|RW), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd10, 1'b0, 32'd0, 32'h0FF0_0FF0, 3'b001));
        vecs.push_back(v("or",    mk(4'(ALU_OR), 3'd6, V|RW), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd11, 1'b0, 32'd0, 32'hFFF0_FFF0, 3'b001));
        vecs.push_back(v("and",   mk(4'(ALU_AND), 3'd7, V|RW), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd12, 1'b0, 32'd0, 32'hF000_F000, 3'b001));
        vecs.push_back(v("store", mk(4'(ALU_ADD), 3'd2, V|MW|UI), 32'h100, 32'hDEAD_BEEF, 32'd8, 32'd0, 5'd0, 1'b0, 32'd8, 32'h108, 3'b010));
        vecs.push_back(v("load",  mk(4'(ALU_ADD), 3'd4, V|MR|RW|UI), 32'h200, 32'd0, 32'd4, 32'd0, 5'd13, 1'b0, 32'd4, 32'h204, 3'b101));
        vecs.push_back(v("inv_st",mk(4'(ALU_ADD), 3'd2, MW|RW), 32'd1, 32'd2, 32'd0, 32'd0, 5'd3, 1'b0, 32'd0, 32'd3, 3'b000));
        vecs.push_back(v("inv_jal",mk(4'(ALU_ADD), 3'd0, JAL), 32'd0, 32'd0, 32'd8, 32'h300, 5'd0, 1'b0, 32'h308, 32'h304, 3'b000));
        vecs.push_back(v("bubble",32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 3'b000));

        // Reset: outputs cleared while combinational outputs follow the inputs
        reset = 1'b1;
        drive(mk(4'(ALU_ADD), 3'd0, V|JAL|RW), 32'd5, 32'd7, 32'd0, 32'h40, 5'd9);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", 64'(bus.result_out), 64'd0);
        chk("rst_reg_write", 64'(bus.reg_write_out), 64'd0);
        chk("rst_rd", 64'(bus.rd_out), 64'd0);
        chk("rst_store_data", 64'(bus.store_data_out), 64'd0);
        chk("rst_branch_follows", 64'(bus.branch), 64'd1);
        chk("rst_stall_low", 64'(bus.stall), 64'd0);
        drive(mk(4'(ALU_ADD), 3'd0, V|MD|RW), 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
        #1;
        chk("rst_stall_follows", 64'(bus.stall), 64'd1);
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single-cycle table
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].ctrl, vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].pc, vecs[i].rd);
            #1;
            chk({vecs[i].name, "_branch"}, 64'(bus.branch), 64'(vecs[i].exp_branch));
            chk({vecs[i].name, "_target"}, 64'(bus.branch_target), 64'(vecs[i].exp_target));
            chk({vecs[i].name, "_stall"}, 64'(bus.stall), 64'd0);
            @(posedge clock); #1;
            chk({vecs[i].name, "_result"}, 64'(bus.result_out), 64'(vecs[i].exp_result));
            chk({vecs[i].name, "_store_data"}, 64'(bus.store_data_out), 64'(vecs[i].d2));
            chk({vecs[i].name, "_rd"}, 64'(bus.rd_out), 64'(vecs[i].rd));
            chk({vecs[i].name, "_flags"},
                64'({bus.mem_read_out, bus.mem_write_out, bus.reg_write_out}),
                64'(vecs[i].exp_flags));
            chk({vecs[i].name, "_mem_size"}, 64'(bus.mem_size_out), 64'(vecs[i].ctrl[6:4]));
        end

        // Muldiv: back-to-back ops, each starting in the cycle after the previous DONE
        @(negedge clock);
        run_md(MD_MUL,    32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, "mul");
        run_md(MD_MULHU,  32'hFFFF_FFFF, 32'd3,         32'h0000_0002, "mulhu");
        run_md(MD_MULH,   32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, "mulh");
        run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, "mulhsu");
        run_md(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_md(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg");
        run_md(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg");
        run_md(MD_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, "divu_zero");
        run_md(MD_REM,    32'd9,         32'd0,         32'd9,         "rem_zero");
        run_md(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_md(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
        run_md(MD_REMU,   32'd9,         32'd4,         32'd1,         "remu");
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);

        // Reset in BUSY cycle 10, then a full restart
        @(negedge clock);
        drive(mk(4'(ALU_ADD), MD_DIV, V|MD|RW), 32'd100, 32'd7, 32'd0, 32'd0, 5'd5);
        @(posedge clock);
        repeat (9) @(posedge clock);
        @(negedge clock);
        chk("busy10_stall", 64'(bus.stall), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("busy_rst_result", 64'(bus.result_out), 64'd0);
        chk("busy_rst_reg_write", 64'(bus.reg_write_out), 64'd0);
        chk("busy_rst_rd", 64'(bus.rd_out), 64'd0);
        chk("busy_rst_stall_follows", 64'(bus.stall), 64'd1);
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("busy_rst_stall_bubble", 64'(bus.stall), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        run_md(MD_DIV, 32'd100, 32'd7, 32'd14, "div_restart");
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clock); #1;
        chk("post_md_reg_write", 64'(bus.reg_write_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline, combined with the EX/MEM pipeline register. It consumes the ID/EX register outputs (operands, destination, immediate, control word, PC) and performs ALU operations, branch/jump resolution, and iterative RV32M multiply/divide. It drives the pipeline-wide `branch` flush, the PC redirect target and the upstream `stall`, and registers its results for the memory stage.

## Interface
- `ENABLE_MULDIV`, default 1: when 0, multiply/divide ops write 0 to the result, take 1 cycle and never assert `stall`.
- `clock`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `d1_in`, `d2_in`  in  32  rs1/rs2 values, already final (no forwarding in this block).
- `rd_in`  in  5  destination register.
- `imm_in`  in  32  sign-extended immediate.
- `ctrl_in`  in  32  control word; layout defined in `ex_pkg`.
- `pc_in`  in  32  instruction PC.
- `branch`  out  1  combinational; taken branch or jump; flushes IF/ID and ID/EX.
- `branch_target`  out  32  combinational; redirect PC.
- `stall`  out  1  combinational; while high, PC, IF/ID and ID/EX hold.
- `result_out`  out  32  registered ALU/jump/muldiv result.
- `store_data_out`  out  32  registered `d2_in`.
- `rd_out`  out  5  registered.
- `mem_read_out`, `mem_write_out`, `reg_write_out`  out  1  registered.
- `mem_size_out`  out  3  registered funct3.

## Operation
- Control word: [3:0] alu_op (0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and); [6:4] funct3; [7] use_imm; [8] br; [9] jal; [10] jalr; [11] lui; [12] auipc; [13] mem_read; [14] mem_write; [15] reg_write; [16] muldiv; [31] valid; all other bits are reserved and zero. All-zero is a bubble.
- Operand B = use_imm ? imm : d2. Shifts use B[4:0]. All arithmetic is modulo 2^32.
- Result priority: jal/jalr → pc+4; lui → imm; auipc → pc+imm; muldiv → unit result; otherwise ALU.
- Branch conditions by funct3: 0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu.
- `branch` = valid & (jal | jalr | (br & cond)).
- Target is pc+imm for br/jal, and (d1+imm) & ~1 for jalr.
- Muldiv funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Multiply is radix-2 shift-add on magnitudes, with sign fix-up. Divide is restoring division on magnitudes, with sign fix-up.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
- DIV 0x80000000 / -1: quotient 0x80000000, remainder 0.
- Muldiv FSM states:
  - IDLE: a valid muldiv op loads the operands and count=32, then goes to BUSY.
  - BUSY: one iteration per cycle; count decrements; at count==1, go to DONE.
  - DONE: result is presented, then go to IDLE.
- `stall` = valid & muldiv & state≠DONE.
- Output register:
  - Each cycle `stall` is high, it loads all zeros (a bubble).
  - Otherwise it loads the computed values. mem/reg-write fields are zero unless valid.

## Timing
- Reset: every registered output is 0, FSM goes to IDLE, count is 0. `branch` and `stall` then follow the inputs combinationally.
- Non-muldiv instructions take 1 cycle: inputs in cycle N appear on the outputs after the edge ending N.
- Muldiv op first presented in cycle 0:
  - `stall` is high in cycles 0–32.
  - Cycle 33 is DONE, with `stall` low.
  - The result is registered at the end of cycle 33.
  - Total occupancy is 34 cycles, with fixed latency including special cases.
- A second muldiv op arriving in the cycle after DONE starts a fresh IDLE→BUSY sequence; there are no back-to-back hazards.
- `branch` is never asserted for a muldiv op. `branch` is evaluated while `stall` is low only.
- The upstream flush takes effect at the same edge at which the branch instruction is registered into EX/MEM.
- Reset during BUSY: at that edge the FSM returns to IDLE, outputs go to 0, and the partial result is discarded.

## Structure
- `ex_pkg` holds:
  - control-word bit positions;
  - alu_op and funct3 encodings;
  - the muldiv FSM state enum (IDLE, BUSY, DONE);
  - the special-case constants.
- Sub-module `muldiv_iter` contains the FSM, counter, and multiplier/divider datapath, with start/op/a/b in and busy/done/result out. `ex_stage` contains the ALU, branch unit, stall logic and output register.

## Test plan
- ALU and immediate path:
  - add d1=5, d2=7 → result 12.
  - sub 5−7 → 0xFFFFFFFE.
  - sra 0x80000000 by imm 4 → 0xF8000000.
  - sltu 1 vs 0xFFFFFFFF → 1.
- Branch and jump resolution:
  - beq with d1=d2=3, pc=0x100, imm=0x20 → `branch`=1, target 0x120.
  - bne with equal operands → `branch`=0.
  - jalr with d1=0x203, imm=0 → target 0x202, result = pc+4.
- MUL timing: MUL 0xFFFFFFFF×3, MULHU of the same operands.
  - `stall` high exactly 33 cycles.
  - Bubbles are registered during the stall.
  - Results are 0xFFFFFFFD and 0x2, on edge 34.
- Divide special cases:
  - DIV −7/2 → −3.
  - REM −7/2 → −1.
  - DIVU 9/0 → 0xFFFFFFFF.
  - REM 9/0 → 9.
  - DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Reset behaviour:
  - Assert reset in BUSY cycle 10 → next cycle all outputs 0, `stall` follows the inputs.
  - Re-presenting the op restarts the full 34-cycle sequence.
